// File: rtl/tpu_top.sv
// tpu_top: 4x4 output-stationary systolic matrix multiplier (C = A * B)
// with single-port word buffers for A, B and the result C.
`timescale 1ns/1ps

module tpu_gbuff #(
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [WORD_BITS-1:0] rdata
);
    logic [WORD_BITS-1:0] gbuff [2**ADDR_BITS];

    // Single port: synchronous write and registered read; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) gbuff[addr] <= wdata;
        rdata <= gbuff[addr];
    end
endmodule

module tpu_top #(
    parameter int DATA_SIZE = 8,
    parameter int ARRAY_DIM = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] m,
    input  logic [3:0] k,
    input  logic [3:0] n,
    output logic       done
);
    localparam int WORD_BITS = DATA_SIZE * ARRAY_DIM;
    localparam int IDX_BITS  = $clog2(ARRAY_DIM);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, FINISHED} state_t;

    state_t state, state_next;
    logic [3:0] m_lat, k_lat, n_lat;
    logic [4:0] cyc_cnt;
    logic [3:0] row_cnt;
    logic       rd_en, rd_valid, out_wr_en, start_job;
    logic [WORD_BITS-1:0] a_rdata, b_rdata, out_wdata, out_rdata_unused;

    logic [DATA_SIZE-1:0] a_lane [ARRAY_DIM];
    logic [DATA_SIZE-1:0] b_lane [ARRAY_DIM];
    logic [DATA_SIZE-1:0] a_edge [ARRAY_DIM];
    logic [DATA_SIZE-1:0] b_edge [ARRAY_DIM];
    logic [DATA_SIZE-1:0] a_line [ARRAY_DIM][ARRAY_DIM-1];
    logic [DATA_SIZE-1:0] b_line [ARRAY_DIM][ARRAY_DIM-1];
    logic [DATA_SIZE-1:0] a_pass [ARRAY_DIM][ARRAY_DIM-1];
    logic [DATA_SIZE-1:0] b_pass [ARRAY_DIM-1][ARRAY_DIM];
    logic [DATA_SIZE-1:0] a_in   [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_SIZE-1:0] b_in   [ARRAY_DIM][ARRAY_DIM];
    logic [DATA_SIZE-1:0] acc    [ARRAY_DIM][ARRAY_DIM];

    tpu_gbuff #(.WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS)) GBUFF_A (
        .clk(clk), .wr_en(1'b0), .addr(ADDR_BITS'(cyc_cnt)), .wdata('0), .rdata(a_rdata)
    );
    tpu_gbuff #(.WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS)) GBUFF_B (
        .clk(clk), .wr_en(1'b0), .addr(ADDR_BITS'(cyc_cnt)), .wdata('0), .rdata(b_rdata)
    );
    tpu_gbuff #(.WORD_BITS(WORD_BITS), .ADDR_BITS(ADDR_BITS)) GBUFF_OUT (
        .clk(clk), .wr_en(out_wr_en), .addr(ADDR_BITS'(row_cnt)), .wdata(out_wdata),
        .rdata(out_rdata_unused)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state and control strobes; a zero dimension jumps straight to FINISHED
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        out_wr_en  = 1'b0;
        start_job  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_job = 1'b1;
                    if (m == 4'd0 || k == 4'd0 || n == 4'd0) state_next = FINISHED;
                    else                                     state_next = FEED;
                end
            end
            FEED: begin
                rd_en = 1'b1;
                if (cyc_cnt == 5'(k_lat) - 5'd1) state_next = DRAIN;
            end
            DRAIN: begin
                if (cyc_cnt == 5'(k_lat) + 5'd6) state_next = WRITE;
            end
            WRITE: begin
                out_wr_en = 1'b1;
                if (row_cnt == m_lat - 4'd1) state_next = FINISHED;
            end
            FINISHED: state_next = FINISHED;
            default:  state_next = IDLE;
        endcase
    end

    assign done = (state == FINISHED);

    // Latch job size and step the read/settle and write-row counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lat    <= '0;
            k_lat    <= '0;
            n_lat    <= '0;
            cyc_cnt  <= '0;
            row_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (start_job) begin
                m_lat   <= m;
                k_lat   <= k;
                n_lat   <= n;
                cyc_cnt <= '0;
                row_cnt <= '0;
            end else begin
                if (state == FEED || state == DRAIN) cyc_cnt <= cyc_cnt + 5'd1;
                if (out_wr_en) row_cnt <= row_cnt + 4'd1;
            end
        end
    end

    // Split read words into lanes, zeroing lanes outside the job and idle cycles
    always_comb begin
        for (int i = 0; i < ARRAY_DIM; i++) begin
            a_lane[i] = (rd_valid && i < int'(m_lat)) ? a_rdata[i*DATA_SIZE +: DATA_SIZE] : '0;
            b_lane[i] = (rd_valid && i < int'(n_lat)) ? b_rdata[i*DATA_SIZE +: DATA_SIZE] : '0;
        end
    end

    // Lane i enters the array i cycles late, tapped from its delay line
    always_comb begin
        a_edge[0] = a_lane[0];
        b_edge[0] = b_lane[0];
        for (int i = 1; i < ARRAY_DIM; i++) begin
            a_edge[i] = a_line[i][i-1];
            b_edge[i] = b_line[i][i-1];
        end
    end

    // A flows left to right: column 0 takes the skewed edge, others the left neighbour
    always_comb begin
        for (int r = 0; r < ARRAY_DIM; r++) begin
            a_in[r][0] = a_edge[r];
            for (int c = 1; c < ARRAY_DIM; c++) a_in[r][c] = a_pass[r][c-1];
        end
    end

    // B flows top to bottom: row 0 takes the skewed edge, others the neighbour above
    always_comb begin
        for (int c = 0; c < ARRAY_DIM; c++) begin
            b_in[0][c] = b_edge[c];
            for (int r = 1; r < ARRAY_DIM; r++) b_in[r][c] = b_pass[r-1][c];
        end
    end

    // Skew delay lines, PE forwarding registers and mod-256 accumulators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARRAY_DIM; i++) begin
                for (int s = 0; s < ARRAY_DIM-1; s++) begin
                    a_line[i][s] <= '0;
                    b_line[i][s] <= '0;
                    a_pass[i][s] <= '0;
                    b_pass[s][i] <= '0;
                end
                for (int j = 0; j < ARRAY_DIM; j++) acc[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < ARRAY_DIM; i++) begin
                a_line[i][0] <= start_job ? '0 : a_lane[i];
                b_line[i][0] <= start_job ? '0 : b_lane[i];
                for (int s = 1; s < ARRAY_DIM-1; s++) begin
                    a_line[i][s] <= start_job ? '0 : a_line[i][s-1];
                    b_line[i][s] <= start_job ? '0 : b_line[i][s-1];
                end
                for (int s = 0; s < ARRAY_DIM-1; s++) begin
                    a_pass[i][s] <= start_job ? '0 : a_in[i][s];
                    b_pass[s][i] <= start_job ? '0 : b_in[s][i];
                end
                for (int j = 0; j < ARRAY_DIM; j++)
                    acc[i][j] <= start_job ? '0 : acc[i][j] + a_in[i][j] * b_in[i][j];
            end
        end
    end

    // Assemble the output word for the current row; columns past n are zero
    always_comb begin
        out_wdata = '0;
        for (int j = 0; j < ARRAY_DIM; j++)
            if (j < int'(n_lat))
                out_wdata[j*DATA_SIZE +: DATA_SIZE] = acc[row_cnt[IDX_BITS-1:0]][j];
    end
endmodule

// File: tb/tb_tpu_top.sv
// tb_tpu_top: table-driven jobs with a scoreboard of expected OUT words,
// plus hand-written reset-abort and post-done sequences.
`timescale 1ns/1ps

module tb_tpu_top;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    typedef struct {
        logic [3:0]        m, k, n;
        logic [3:0][31:0]  a;
        logic [3:0][31:0]  b;
        logic [3:0][31:0]  c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] m, k, n;
    logic       done;
    int         errors = 0;
    int         checks = 0;
    logic [31:0] sb [$];

    tpu_top dut (.clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n), .done(done));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] model_c(input vec_t v);
        logic [3:0][31:0] c;
        logic [7:0] s;
        for (int i = 0; i < 4; i++) begin
            c[i] = SENT;
            if (i < int'(v.m) && v.k != 0 && v.n != 0) begin
                c[i] = '0;
                for (int j = 0; j < int'(v.n); j++) begin
                    s = '0;
                    for (int t = 0; t < int'(v.k); t++)
                        s = s + v.a[t][i*8 +: 8] * v.b[t][j*8 +: 8];
                    c[i][j*8 +: 8] = s;
                end
            end
        end
        return c;
    endfunction

    // Reset, preload buffers, release and request the job; expectations go to the scoreboard
    task automatic apply_stimulus(input vec_t v);
        rst = 1'b0; start = 1'b0; m = '0; k = '0; n = '0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dut.GBUFF_A.gbuff[i]   = v.a[i];
            dut.GBUFF_B.gbuff[i]   = v.b[i];
            dut.GBUFF_OUT.gbuff[i] = SENT;
        end
        @(negedge clk);
        check("reset done", {31'b0, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) sb.push_back(v.c[i]);
        start = 1'b1; m = v.m; k = v.k; n = v.n;
    endtask

    task automatic wait_done(input vec_t v, input int cyc0);
        int cyc;
        int limit;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        check("done asserted", {31'b0, done}, 32'd1);
        limit = 2 * int'(v.k) + int'(v.m) + 10;
        checks++;
        if (cyc - 1 > limit) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles required <= %0d", cyc - 1, limit);
        end
    endtask

    task automatic check_output();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("[TB] FAIL scoreboard empty: got 0 entries required 1");
            end else begin
                exp = sb.pop_front();
                check($sformatf("out[%0d]", i), dut.GBUFF_OUT.gbuff[i], exp);
            end
        end
    endtask

    // Full job; m/k/n are scrambled right after acceptance to prove they are latched
    task automatic run_job(input vec_t v);
        apply_stimulus(v);
        @(posedge clk);
        @(negedge clk);
        m = ~v.m; k = ~v.k; n = ~v.n;
        wait_done(v, 1);
        check_output();
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        vec_t vid;

        rst = 1'b0; start = 1'b0; m = '0; k = '0; n = '0;

        v.m = 4; v.k = 4; v.n = 4;
        v.a = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
        v.b = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};
        v.c = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};
        vecs.push_back(v);
        vid = v;

        v.m = 4; v.k = 4; v.n = 4;
        v.a = {4{32'h02020202}};
        v.b = {4{32'h03030303}};
        v.c = {4{32'h18181818}};
        vecs.push_back(v);

        v.m = 2; v.k = 1; v.n = 3;
        v.a = {32'h11111111, 32'h11111111, 32'h11111111, 32'hABCD0605};
        v.b = {32'h22222222, 32'h22222222, 32'h22222222, 32'h55030201};
        v.c = {SENT, SENT, 32'h00120C06, 32'h000F0A05};
        vecs.push_back(v);

        v.m = 1; v.k = 1; v.n = 1;
        v.a = {32'h33333333, 32'h33333333, 32'h33333333, 32'h99999910};
        v.b = {32'h44444444, 32'h44444444, 32'h44444444, 32'h77777710};
        v.c = {SENT, SENT, SENT, 32'h00000000};
        vecs.push_back(v);

        v.m = 3; v.k = 4; v.n = 2;
        v.a = {4{32'hFFFFFFFF}};
        v.b = {4{32'h01010101}};
        v.c = {SENT, 32'h0000FCFC, 32'h0000FCFC, 32'h0000FCFC};
        vecs.push_back(v);

        v.m = 0; v.k = 2; v.n = 3;
        v.a = {4{32'h05050505}};
        v.b = {4{32'h07070707}};
        v.c = {SENT, SENT, SENT, SENT};
        vecs.push_back(v);

        for (int r = 0; r < 2; r++) begin
            v.m = 4'($urandom_range(1, 4));
            v.k = 4'($urandom_range(1, 4));
            v.n = 4'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) begin
                v.a[i] = $urandom;
                v.b[i] = $urandom;
            end
            v.c = model_c(v);
            vecs.push_back(v);
        end

        foreach (vecs[i]) run_job(vecs[i]);

        // Reset in the middle of FEED, then rerun on release with start still high
        apply_stimulus(vid);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("done after mid-job reset", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("out[0] untouched by aborted job", dut.GBUFF_OUT.gbuff[0], SENT);
        rst = 1'b1;
        wait_done(vid, 0);
        check_output();

        // start held high after done: no restart and no rewrite of OUT
        dut.GBUFF_OUT.gbuff[0] = 32'hA5A5A5A5;
        repeat (8) @(negedge clk);
        check("out[0] not rewritten", dut.GBUFF_OUT.gbuff[0], 32'hA5A5A5A5);
        check("done held", {31'b0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
